// File: rtl/sign_unit_if.sv
// Request/response bundle for sign_unit: one request per cycle in, one registered result out.
interface sign_unit_if #(
   parameter int L = 4
);
   // Valid-only handshake: the unit is always ready, so in_valid=1 at a rising
   // edge is an accepted request and out_valid=1 marks its result one cycle later.
   logic         in_valid;
   logic [1:0]   op;
   logic         sign;
   logic [L-1:0] data_in;
   logic [L-1:0] result;
   logic         overflow;
   logic         out_valid;

   modport master (
      output in_valid, op, sign, data_in,
      input  result, overflow, out_valid
   );

   modport slave (
      input  in_valid, op, sign, data_in,
      output result, overflow, out_valid
   );
endinterface

// File: rtl/sign_unit.sv
// Registered sign-manipulation unit: negate, absolute value, or apply a sign
// to an unsigned magnitude, with one-cycle latency and no backpressure.
module sign_unit #(
   parameter int L = 4
) (
   input  logic        clk,
   input  logic        rst,
   sign_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      OP_INVERT   = 2'b00,
      OP_ABS      = 2'b01,
      OP_GIVESIGN = 2'b10,
      OP_RSVD     = 2'b11
   } op_e;

   localparam logic [L-1:0] MIN_VAL = {1'b1, {(L-1){1'b0}}};

   logic [L-1:0] result_d, result_q;
   logic         overflow_d, overflow_q;
   logic         out_valid_d, out_valid_q;

   logic [L-1:0] neg_val;
   logic [L-1:0] calc_res;
   logic         calc_ovf;

   // Every negating path shares this one incrementer on the inverted operand.
   assign neg_val = ~bus.data_in + {{(L-1){1'b0}}, 1'b1};

   always_comb begin
      calc_res = '0;
      calc_ovf = 1'b0;
      case (op_e'(bus.op))
         OP_INVERT: begin
            calc_res = neg_val;
            calc_ovf = (bus.data_in == MIN_VAL);
         end
         OP_ABS: begin
            calc_res = bus.data_in[L-1] ? neg_val : bus.data_in;
         end
         OP_GIVESIGN: begin
            if (bus.sign) begin
               calc_res = neg_val;
               calc_ovf = (bus.data_in > MIN_VAL);
            end else begin
               // Magnitudes above MAXP pass through unchanged but are flagged.
               calc_res = bus.data_in;
               calc_ovf = bus.data_in[L-1];
            end
         end
         default: begin
            calc_res = '0;
            calc_ovf = 1'b0;
         end
      endcase
   end

   always_comb begin
      result_d    = result_q;
      overflow_d  = overflow_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         result_d   = calc_res;
         overflow_d = calc_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_unit.sv
// Directed and random checks of sign_unit against an integer reference model.
module tb_sign_unit;
   localparam int L    = 4;
   localparam int HALF = 2 ** (L - 1);

   logic clk;
   logic rst;

   sign_unit_if #(.L(L)) bus ();

   sign_unit #(.L(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [L:0]   exp_q[$];
   int           n_cmp;
   int           n_bad;
   logic [L-1:0] last_res;
   logic         last_ovf;

   function automatic logic [L:0] model(input logic [1:0] o, input logic s,
                                        input logic [L-1:0] d);
      int          m, sv, r;
      logic        of;
      logic [31:0] rv;
      m  = int'(d);
      sv = (m >= HALF) ? m - 2 * HALF : m;
      r  = 0;
      of = 1'b0;
      case (o)
         2'b00: begin r = -sv; of = (sv == -HALF); end
         2'b01: r = (sv < 0) ? -sv : sv;
         2'b10: begin
            if (!s) begin r = m;  of = (m > HALF - 1); end
            else    begin r = -m; of = (m > HALF);     end
         end
         default: r = 0;
      endcase
      rv = r;
      return {rv[L-1:0], of};
   endfunction

   task automatic chk(input string tag, input logic [L:0] obs, input logic [L:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] o, input logic s,
                       input logic [L-1:0] d);
      logic [L:0] e;
      bus.in_valid = v;
      bus.op       = o;
      bus.sign     = s;
      bus.data_in  = d;
      if (v) exp_q.push_back(model(o, s, d));
      @(posedge clk);
      #1;
      chk("out_valid", {{L{1'b0}}, bus.out_valid}, {{L{1'b0}}, v});
      if (v) begin
         if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("result",   {1'b0, bus.result}, {1'b0, e[L:1]});
            chk("overflow", {{L{1'b0}}, bus.overflow}, {{L{1'b0}}, e[0]});
            last_res = e[L:1];
            last_ovf = e[0];
         end
      end else begin
         chk("result_hold",   {1'b0, bus.result}, {1'b0, last_res});
         chk("overflow_hold", {{L{1'b0}}, bus.overflow}, {{L{1'b0}}, last_ovf});
      end
   endtask

   task automatic reset_check(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_result"},    {1'b0, bus.result}, '0);
      chk({tag, "_overflow"},  {{L{1'b0}}, bus.overflow}, '0);
      chk({tag, "_out_valid"}, {{L{1'b0}}, bus.out_valid}, '0);
      last_res = '0;
      last_ovf = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      last_res = '0;
      last_ovf = 1'b0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.op       = 2'b00;
      bus.sign     = 1'b0;
      bus.data_in  = '0;
      @(posedge clk);
      reset_check("reset");
      rst = 1'b0;

      // INVERT
      step(1, 2'b00, 0, 4'hF);
      step(1, 2'b00, 0, 4'h8);
      step(1, 2'b00, 0, 4'h7);
      step(1, 2'b00, 0, 4'h5);
      // ABS
      step(1, 2'b01, 0, 4'hF);
      step(1, 2'b01, 0, 4'h8);
      step(1, 2'b01, 0, 4'h7);
      step(1, 2'b01, 0, 4'hB);
      // GIVESIGN
      step(1, 2'b10, 0, 4'h5);
      step(1, 2'b10, 0, 4'h8);
      step(1, 2'b10, 1, 4'h8);
      step(1, 2'b10, 1, 4'h5);
      step(1, 2'b10, 1, 4'h9);
      step(1, 2'b10, 1, 4'h0);
      // idle: out_valid drops, result/overflow hold
      step(0, 2'b00, 0, 4'h3);
      step(0, 2'b10, 1, 4'hC);
      // reserved
      step(1, 2'b11, 0, 4'h5);
      // three back-to-back then idle
      step(1, 2'b00, 0, 4'h3);
      step(1, 2'b01, 0, 4'hC);
      step(1, 2'b10, 1, 4'hF);
      step(0, 2'b00, 0, 4'h0);

      // reset wins over a simultaneous request
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.op       = 2'b00;
      bus.data_in  = 4'h8;
      reset_check("rst_priority");
      rst = 1'b0;
      step(0, 2'b00, 0, 4'h0);

      for (int i = 0; i < 60; i++) begin
         step(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      step(0, 2'b00, 0, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
